// File: rtl/mem_stage_pkg.sv
// Shared core types for the memory stage: instruction records, memory
// function codes, the stage FSM encoding and the writeback record.
package ProcTypes;

  typedef enum logic [3:0] {
    OP, OPIMM, LUI, AUIPC, BRANCH, JAL, JALR, LOAD, STORE, UNSUPPORTED
  } IType;

  typedef enum logic [2:0] {
    LW, LH, LHU, LB, LBU, SW, SH, SB
  } MemFunc;

  typedef struct packed {
    IType        iType;
    MemFunc      memFunc;
    logic [4:0]  dst;
    logic [31:0] data;
    logic [31:0] addr;
    logic [31:0] nextPc;
  } ExecInst;

  typedef enum logic [1:0] {
    IDLE, REQ, RESP, WB
  } MemStageState;

  typedef struct packed {
    logic [4:0]  dst;
    logic [31:0] data;
    logic        we;
  } WbInst;

  // Instruction classes that never update the register file.
  function automatic logic writesReg(IType t);
    return !(t inside {STORE, BRANCH, UNSUPPORTED});
  endfunction

endpackage

// File: rtl/mem_stage_align.sv
// Byte-lane logic for data memory: store strobes and lane replication,
// load extraction with sign/zero extension, and misalignment detection.
module mem_align
  import ProcTypes::*;
(
  input  MemFunc      memFunc,
  input  logic [1:0]  addrLow,
  input  logic [31:0] storeData,
  input  logic [31:0] respData,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] loadData,
  output logic        misaligned
);

  logic [31:0] shifted;

  always_comb begin
    shifted    = respData >> {addrLow, 3'b000};
    wstrb      = 4'b0000;
    wdata      = storeData;
    loadData   = shifted;
    misaligned = 1'b0;
    unique case (memFunc)
      LW: misaligned = (addrLow != 2'b00);
      LH: begin
        misaligned = addrLow[0];
        loadData   = {{16{shifted[15]}}, shifted[15:0]};
      end
      LHU: begin
        misaligned = addrLow[0];
        loadData   = {16'h0000, shifted[15:0]};
      end
      LB:  loadData = {{24{shifted[7]}}, shifted[7:0]};
      LBU: loadData = {24'h000000, shifted[7:0]};
      SW: begin
        misaligned = (addrLow != 2'b00);
        wstrb      = 4'b1111;
      end
      SH: begin
        misaligned = addrLow[0];
        wstrb      = 4'b0011 << addrLow;
        wdata      = {2{storeData[15:0]}};
      end
      SB: begin
        wstrb = 4'b0001 << addrLow;
        wdata = {4{storeData[7:0]}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: holds one instruction, runs its load/store against
// data memory, then offers a single writeback record.
module mem_stage
  import ProcTypes::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        e_valid_in,
  output logic        e_ready_out,
  input  ExecInst     e_inst_in,
  output logic        dmem_req_valid_out,
  input  logic        dmem_req_ready_in,
  output logic [31:0] dmem_req_addr_out,
  output logic [31:0] dmem_req_wdata_out,
  output logic [3:0]  dmem_req_wstrb_out,
  input  logic        dmem_resp_valid_in,
  input  logic [31:0] dmem_resp_data_in,
  output logic        wb_valid_out,
  input  logic        wb_ready_in,
  output logic [4:0]  wb_dst_out,
  output logic [31:0] wb_data_out,
  output logic        wb_we_out,
  output logic        misaligned_out
);

  MemStageState stateReg, stateNext;
  ExecInst      instReg, instNext;
  WbInst        wbReg, wbNext;
  logic         misReg, misNext;
  logic         readyReg;

  ExecInst      curInst;
  logic [3:0]   alignWstrb;
  logic [31:0]  alignWdata, alignLoad;
  logic         alignMis, memAccess, misAccess, accept, inReq, inWb;
  logic         unusedCur;

  // The lane logic looks at the incoming instruction while idle so the
  // misalignment decision is made in the accept cycle.
  assign curInst   = (stateReg == IDLE) ? e_inst_in : instReg;
  assign unusedCur = ^{curInst.dst, curInst.addr[31:2], curInst.nextPc};

  mem_align uAlign (
    .memFunc   (curInst.memFunc),
    .addrLow   (curInst.addr[1:0]),
    .storeData (curInst.data),
    .respData  (dmem_resp_data_in),
    .wstrb     (alignWstrb),
    .wdata     (alignWdata),
    .loadData  (alignLoad),
    .misaligned(alignMis)
  );

  assign memAccess = (curInst.iType == LOAD) || (curInst.iType == STORE);
  assign misAccess = memAccess && alignMis;
  assign accept    = e_valid_in && e_ready_out;
  assign inReq     = (stateReg == REQ);
  assign inWb      = (stateReg == WB);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      stateReg <= IDLE;
      instReg  <= '0;
      wbReg    <= '0;
      misReg   <= 1'b0;
      readyReg <= 1'b0;
    end else begin
      stateReg <= stateNext;
      instReg  <= instNext;
      wbReg    <= wbNext;
      misReg   <= misNext;
      readyReg <= 1'b1;
    end
  end

  always_comb begin
    stateNext = stateReg;
    instNext  = instReg;
    wbNext    = wbReg;
    misNext   = 1'b0;
    unique case (stateReg)
      IDLE: begin
        if (accept) begin
          instNext = e_inst_in;
          if (memAccess && !alignMis) begin
            stateNext = REQ;
          end else begin
            stateNext = WB;
            misNext   = misAccess;
            wbNext    = '{dst:  e_inst_in.dst,
                          data: misAccess ? 32'h0 : e_inst_in.data,
                          we:   !misAccess && writesReg(e_inst_in.iType)
                                && (e_inst_in.dst != 5'd0)};
          end
        end
      end
      REQ: begin
        if (dmem_req_ready_in) begin
          if (instReg.iType == LOAD) begin
            stateNext = RESP;
          end else begin
            stateNext = WB;
            wbNext    = '{dst: instReg.dst, data: 32'h0, we: 1'b0};
          end
        end
      end
      RESP: begin
        if (dmem_resp_valid_in) begin
          stateNext = WB;
          wbNext    = '{dst: instReg.dst, data: alignLoad, we: instReg.dst != 5'd0};
        end
      end
      WB: begin
        if (wb_ready_in) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign e_ready_out        = (stateReg == IDLE) && readyReg;
  assign dmem_req_valid_out = inReq;
  assign dmem_req_addr_out  = inReq ? {instReg.addr[31:2], 2'b00} : 32'h0;
  assign dmem_req_wdata_out = inReq ? alignWdata : 32'h0;
  assign dmem_req_wstrb_out = inReq ? alignWstrb : 4'b0000;
  assign wb_valid_out       = inWb;
  assign wb_dst_out         = inWb ? wbReg.dst : 5'd0;
  assign wb_data_out        = inWb ? wbReg.data : 32'h0;
  assign wb_we_out          = inWb && wbReg.we;
  assign misaligned_out     = misReg;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, corner sequences, and
// randomized transactions checked against a byte-arithmetic model.
module tb_mem_stage;
  import ProcTypes::*;

  logic        clk_in, rst_in;
  logic        e_valid_in, e_ready_out;
  ExecInst     e_inst_in;
  logic        dmem_req_valid_out, dmem_req_ready_in;
  logic [31:0] dmem_req_addr_out, dmem_req_wdata_out;
  logic [3:0]  dmem_req_wstrb_out;
  logic        dmem_resp_valid_in;
  logic [31:0] dmem_resp_data_in;
  logic        wb_valid_out, wb_ready_in;
  logic [4:0]  wb_dst_out;
  logic [31:0] wb_data_out;
  logic        wb_we_out, misaligned_out;

  mem_stage dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .e_valid_in(e_valid_in), .e_ready_out(e_ready_out), .e_inst_in(e_inst_in),
    .dmem_req_valid_out(dmem_req_valid_out), .dmem_req_ready_in(dmem_req_ready_in),
    .dmem_req_addr_out(dmem_req_addr_out), .dmem_req_wdata_out(dmem_req_wdata_out),
    .dmem_req_wstrb_out(dmem_req_wstrb_out),
    .dmem_resp_valid_in(dmem_resp_valid_in), .dmem_resp_data_in(dmem_resp_data_in),
    .wb_valid_out(wb_valid_out), .wb_ready_in(wb_ready_in),
    .wb_dst_out(wb_dst_out), .wb_data_out(wb_data_out), .wb_we_out(wb_we_out),
    .misaligned_out(misaligned_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    bit          isReq;
    logic [31:0] reqAddr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    bit          mis;
    logic [4:0]  wbDst;
    logic [31:0] wbData;
    bit          wbWe;
  } Expect;

  typedef struct {
    ExecInst     inst;
    logic [31:0] resp;
    int          reqDelay;
    int          respDelay;
    int          wbDelay;
    Expect       ex;
  } Vec;

  int    nChecks = 0;
  int    nFail   = 0;
  int    txnCount = 0;
  string curTag  = "";

  task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL [%s] %s: got %h, expected %h", curTag, name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checkEq(name, {31'b0, act}, {31'b0, exp});
  endtask

  function automatic ExecInst mkInst(IType t, MemFunc f, logic [4:0] d, logic [31:0] data, logic [31:0] addr);
    ExecInst i;
    i.iType = t; i.memFunc = f; i.dst = d; i.data = data; i.addr = addr; i.nextPc = $urandom;
    return i;
  endfunction

  function automatic Expect mkExp(bit isReq, logic [31:0] a, logic [3:0] s, logic [31:0] w,
                                  bit mis, logic [4:0] d, logic [31:0] data, bit we);
    Expect e;
    e.isReq = isReq; e.reqAddr = a; e.wstrb = s; e.wdata = w;
    e.mis = mis; e.wbDst = d; e.wbData = data; e.wbWe = we;
    return e;
  endfunction

  function automatic ExecInst randomInst();
    return mkInst(IType'($urandom_range(0, 9)), MemFunc'($urandom_range(0, 7)),
                  5'($urandom), $urandom, $urandom);
  endfunction

  // Reference: access size in bytes, offset arithmetic on integers.
  function automatic Expect model(ExecInst inst, logic [31:0] resp);
    Expect e;
    int size, off;
    bit sgn;
    longint v;
    logic [31:0] wd;
    off = int'(inst.addr % 4);
    case (inst.memFunc)
      LW, SW:      begin size = 4; sgn = 0; end
      LH:          begin size = 2; sgn = 1; end
      LHU, SH:     begin size = 2; sgn = 0; end
      LB:          begin size = 1; sgn = 1; end
      default:     begin size = 1; sgn = 0; end
    endcase
    e = mkExp(0, 0, 0, 0, 0, inst.dst, 0, 0);
    if (inst.iType == LOAD || inst.iType == STORE) begin
      if (off % size != 0) begin
        e.mis = 1;
      end else begin
        e.isReq   = 1;
        e.reqAddr = inst.addr - 32'(off);
        if (inst.iType == STORE) begin
          e.wstrb = 4'(((1 << size) - 1) << off);
          for (int b = 0; b < 4; b++) wd[8*b +: 8] = 8'(inst.data >> (8 * (b % size)));
          e.wdata = wd;
        end else begin
          v = (longint'(resp) >> (8 * off)) % (longint'(1) << (8 * size));
          if (sgn && v >= (longint'(1) << (8 * size - 1))) v = v - (longint'(1) << (8 * size));
          e.wbData = 32'(v);
          e.wbWe   = (inst.dst != 0);
        end
      end
    end else begin
      e.wbData = inst.data;
      e.wbWe   = !(inst.iType == BRANCH || inst.iType == UNSUPPORTED) && inst.dst != 0;
    end
    return e;
  endfunction

  task automatic doTxn(input ExecInst inst, input Expect ex, input logic [31:0] respWord,
                       input int reqDelay, input int respDelay, input int wbDelay);
    int waitCyc = 0;
    while (!e_ready_out && waitCyc < 20) begin
      @(negedge clk_in);
      waitCyc++;
    end
    chk1("e_ready before accept", e_ready_out, 1'b1);
    e_valid_in = 1'b1;
    e_inst_in  = inst;
    @(negedge clk_in);
    e_valid_in = 1'b0;
    e_inst_in  = randomInst();
    chk1("e_ready after accept", e_ready_out, 1'b0);
    chk1("req valid", dmem_req_valid_out, ex.isReq);
    if (ex.isReq) begin
      for (int i = 0; i <= reqDelay; i++) begin
        if (i > 0) chk1("req valid held", dmem_req_valid_out, 1'b1);
        checkEq("req addr", dmem_req_addr_out, ex.reqAddr);
        checkEq("req wstrb", {28'b0, dmem_req_wstrb_out}, {28'b0, ex.wstrb});
        if (ex.wstrb != 4'b0000) checkEq("req wdata", dmem_req_wdata_out, ex.wdata);
        chk1("no wb during req", wb_valid_out, 1'b0);
        if (i < reqDelay) begin
          dmem_resp_valid_in = 1'($urandom_range(0, 1));
          dmem_resp_data_in  = $urandom;
        end else begin
          dmem_resp_valid_in = 1'b0;
          dmem_req_ready_in  = 1'b1;
        end
        @(negedge clk_in);
      end
      dmem_req_ready_in = 1'b0;
      chk1("req dropped", dmem_req_valid_out, 1'b0);
      if (ex.wstrb == 4'b0000) begin
        for (int i = 0; i < respDelay; i++) begin
          chk1("no wb before resp", wb_valid_out, 1'b0);
          @(negedge clk_in);
        end
        dmem_resp_valid_in = 1'b1;
        dmem_resp_data_in  = respWord;
        @(negedge clk_in);
        dmem_resp_valid_in = 1'b0;
        dmem_resp_data_in  = $urandom;
      end
    end
    chk1("wb valid", wb_valid_out, 1'b1);
    chk1("misaligned pulse", misaligned_out, ex.mis);
    for (int i = 0; i <= wbDelay; i++) begin
      if (i > 0) begin
        chk1("wb valid held", wb_valid_out, 1'b1);
        chk1("misaligned single cycle", misaligned_out, 1'b0);
      end
      checkEq("wb dst", {27'b0, wb_dst_out}, {27'b0, ex.wbDst});
      checkEq("wb data", wb_data_out, ex.wbData);
      chk1("wb we", wb_we_out, ex.wbWe);
      chk1("e_ready low in wb", e_ready_out, 1'b0);
      wb_ready_in = (i == wbDelay);
      @(negedge clk_in);
    end
    wb_ready_in = 1'b0;
    chk1("wb consumed", wb_valid_out, 1'b0);
    chk1("misaligned clear", misaligned_out, 1'b0);
    chk1("e_ready after wb", e_ready_out, 1'b1);
    $display("txn %0d %s type=%s func=%s addr=%h data=%h -> wb_data=%h we=%0b mis=%0b",
             txnCount, curTag, inst.iType.name(), inst.memFunc.name(), inst.addr,
             inst.data, ex.wbData, ex.wbWe, ex.mis);
    txnCount++;
  endtask

  Vec vecs[18];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    ExecInst ri;
    rst_in = 1'b1; e_valid_in = 1'b0; e_inst_in = '0;
    dmem_req_ready_in = 1'b0; dmem_resp_valid_in = 1'b0; dmem_resp_data_in = '0;
    wb_ready_in = 1'b0;

    vecs[0]  = '{mkInst(OP, LW, 5, 32'h1234, 0), 0, 0, 0, 0, mkExp(0, 0, 0, 0, 0, 5, 32'h1234, 1)};
    vecs[1]  = '{mkInst(LOAD, LB, 7, 0, 32'h103), 32'h80FF_0000, 0, 0, 0, mkExp(1, 32'h100, 0, 0, 0, 7, 32'hFFFF_FF80, 1)};
    vecs[2]  = '{mkInst(STORE, SH, 0, 32'hABCD_5678, 32'h202), 0, 3, 0, 0, mkExp(1, 32'h200, 4'b1100, 32'h5678_5678, 0, 0, 0, 0)};
    vecs[3]  = '{mkInst(LOAD, LW, 9, 0, 32'h101), 0, 0, 0, 2, mkExp(0, 0, 0, 0, 1, 9, 0, 0)};
    vecs[4]  = '{mkInst(LOAD, LHU, 4, 0, 32'h2), 32'hBEEF_0000, 0, 1, 4, mkExp(1, 0, 0, 0, 0, 4, 32'h0000_BEEF, 1)};
    vecs[5]  = '{mkInst(JAL, LW, 1, 32'h108, 0), 0, 0, 0, 0, mkExp(0, 0, 0, 0, 0, 1, 32'h108, 1)};
    vecs[6]  = '{mkInst(BRANCH, LW, 3, 32'h1, 0), 0, 0, 0, 0, mkExp(0, 0, 0, 0, 0, 3, 32'h1, 0)};
    vecs[7]  = '{mkInst(OP, LW, 0, 32'h55, 0), 0, 0, 0, 0, mkExp(0, 0, 0, 0, 0, 0, 32'h55, 0)};
    vecs[8]  = '{mkInst(UNSUPPORTED, LW, 8, 32'h77, 0), 0, 0, 0, 0, mkExp(0, 0, 0, 0, 0, 8, 32'h77, 0)};
    vecs[9]  = '{mkInst(STORE, SB, 0, 32'h1234_5699, 32'h301), 0, 1, 0, 0, mkExp(1, 32'h300, 4'b0010, 32'h9999_9999, 0, 0, 0, 0)};
    vecs[10] = '{mkInst(LOAD, LH, 2, 0, 32'h13), 0, 0, 0, 0, mkExp(0, 0, 0, 0, 1, 2, 0, 0)};
    vecs[11] = '{mkInst(STORE, SW, 0, 32'hDEAD_BEEF, 32'h400), 0, 0, 0, 0, mkExp(1, 32'h400, 4'b1111, 32'hDEAD_BEEF, 0, 0, 0, 0)};
    vecs[12] = '{mkInst(LOAD, LH, 10, 0, 32'h2), 32'h8001_1234, 0, 2, 0, mkExp(1, 0, 0, 0, 0, 10, 32'hFFFF_8001, 1)};
    vecs[13] = '{mkInst(LOAD, LBU, 11, 0, 32'h1), 32'h1234_F1AB, 0, 0, 0, mkExp(1, 0, 0, 0, 0, 11, 32'h0000_00F1, 1)};
    vecs[14] = '{mkInst(LOAD, LW, 0, 0, 32'h8), 32'hCAFE_BABE, 0, 0, 0, mkExp(1, 32'h8, 0, 0, 0, 0, 32'hCAFE_BABE, 0)};
    vecs[15] = '{mkInst(STORE, SB, 0, 32'h0000_00AB, 32'h7), 0, 2, 0, 0, mkExp(1, 32'h4, 4'b1000, 32'hABAB_ABAB, 0, 0, 0, 0)};
    vecs[16] = '{mkInst(STORE, SW, 0, 32'h1111_2222, 32'h402), 0, 0, 0, 1, mkExp(0, 0, 0, 0, 1, 0, 0, 0)};
    vecs[17] = '{mkInst(JALR, LW, 31, 32'h2004, 0), 0, 0, 0, 0, mkExp(0, 0, 0, 0, 0, 31, 32'h2004, 1)};

    // Reset state, then ready rises one cycle after release.
    curTag = "reset";
    @(negedge clk_in);
    @(negedge clk_in);
    chk1("e_ready in reset", e_ready_out, 1'b0);
    chk1("req valid in reset", dmem_req_valid_out, 1'b0);
    checkEq("req addr in reset", dmem_req_addr_out, 32'h0);
    chk1("wb valid in reset", wb_valid_out, 1'b0);
    checkEq("wb data in reset", wb_data_out, 32'h0);
    chk1("misaligned in reset", misaligned_out, 1'b0);
    rst_in = 1'b0;
    #1;
    chk1("e_ready at release", e_ready_out, 1'b0);
    @(negedge clk_in);
    chk1("e_ready after release", e_ready_out, 1'b1);

    for (int v = 0; v < 18; v++) begin
      curTag = $sformatf("vec%0d", v);
      doTxn(vecs[v].inst, vecs[v].ex, vecs[v].resp, vecs[v].reqDelay, vecs[v].respDelay, vecs[v].wbDelay);
    end

    // Back-to-back pass-through with wb_ready held high: accept, WB, accept, ...
    curTag = "throughput";
    wb_ready_in = 1'b1;
    e_valid_in  = 1'b1;
    e_inst_in   = mkInst(OP, LW, 12, 32'h100, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_in);
      chk1("b2b wb valid", wb_valid_out, 1'b1);
      checkEq("b2b wb data", wb_data_out, 32'h100 + 32'(k));
      chk1("b2b e_ready low", e_ready_out, 1'b0);
      e_inst_in = mkInst(OP, LW, 12, 32'h100 + 32'(k + 1), 0);
      @(negedge clk_in);
      chk1("b2b wb idle", wb_valid_out, 1'b0);
      chk1("b2b e_ready high", e_ready_out, 1'b1);
      if (k == 2) e_valid_in = 1'b0;
    end
    wb_ready_in = 1'b0;
    $display("txn %0d throughput: 3 pass-through instructions in 6 cycles", txnCount);
    txnCount++;

    // Reset while waiting for a load response.
    curTag = "reset in RESP";
    e_valid_in = 1'b1;
    e_inst_in  = mkInst(LOAD, LW, 6, 0, 32'h10);
    @(negedge clk_in);
    e_valid_in = 1'b0;
    chk1("rr req valid", dmem_req_valid_out, 1'b1);
    dmem_req_ready_in = 1'b1;
    @(negedge clk_in);
    dmem_req_ready_in = 1'b0;
    chk1("rr in resp no wb", wb_valid_out, 1'b0);
    #2 rst_in = 1'b1;
    #1;
    chk1("rr async e_ready", e_ready_out, 1'b0);
    chk1("rr async req", dmem_req_valid_out, 1'b0);
    chk1("rr async wb", wb_valid_out, 1'b0);
    @(negedge clk_in);
    dmem_resp_valid_in = 1'b1;
    dmem_resp_data_in  = 32'h5A5A_5A5A;
    @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
    chk1("rr late resp ignored", wb_valid_out, 1'b0);
    chk1("rr ready after reset", e_ready_out, 1'b1);
    @(negedge clk_in);
    chk1("rr still idle", wb_valid_out, 1'b0);
    dmem_resp_valid_in = 1'b0;
    $display("txn %0d reset during RESP: load abandoned", txnCount);
    txnCount++;
    doTxn(vecs[0].inst, vecs[0].ex, 0, 0, 0, 0);

    // Randomized transactions against the reference model.
    for (int n = 0; n < 60; n++) begin
      int r;
      logic [31:0] resp;
      curTag = $sformatf("rand%0d", n);
      r  = int'($urandom_range(0, 15));
      ri = randomInst();
      if (r >= 10) begin
        ri.iType   = (r < 13) ? LOAD : STORE;
        ri.memFunc = (ri.iType == LOAD) ? MemFunc'($urandom_range(0, 4)) : MemFunc'($urandom_range(5, 7));
      end else if (ri.iType == LOAD || ri.iType == STORE) begin
        ri.iType = OPIMM;
      end
      resp = $urandom;
      doTxn(ri, model(ri, resp), resp, int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the basic RV32I core, placed directly downstream of execute. Consumes one `ExecInst` per handshake, performs any load or store against the data memory over a valid/ready request port and a valid response port, then presents one writeback record (destination, data, write-enable) to the register-file writeback stage. Holds one instruction at a time; non-memory instructions pass through with a single registered cycle.

## Interface
- No parameters; all datapaths are fixed RV32 widths (32-bit data/addr, 5-bit register index).

- `clk_in`  in  1  system clock
- `rst_in`  in  1  asynchronous, active-high reset
- `e_valid_in`  in  1  execute offers an instruction
- `e_ready_out`  out  1  stage can accept; high only in IDLE
- `e_inst_in`  in  `ExecInst`  iType, memFunc, dst, data (ALU result / store data), addr, nextPc
- `dmem_req_valid_out`  out  1  memory request pending
- `dmem_req_ready_in`  in  1  memory accepts request this cycle
- `dmem_req_addr_out`  out  32  word-aligned address ({addr[31:2],2'b00})
- `dmem_req_wdata_out`  out  32  lane-replicated store data
- `dmem_req_wstrb_out`  out  4  byte strobes; 4'b0000 = read
- `dmem_resp_valid_in`  in  1  load data valid (reads only; stores get no response)
- `dmem_resp_data_in`  in  32  raw word read
- `wb_valid_out`  out  1  writeback record valid
- `wb_ready_in`  in  1  writeback consumes record
- `wb_dst_out`  out  5  destination register
- `wb_data_out`  out  32  value to write
- `wb_we_out`  out  1  register write enable
- `misaligned_out`  out  1  one-cycle pulse on misaligned access

## Operation
- States: IDLE, REQ, RESP, WB.
- IDLE: e_ready_out=1. On e_valid_in, latch e_inst_in. LOAD/STORE aligned -> REQ; misaligned -> WB with we=0 and misaligned_out pulsed the following cycle; all other iTypes -> WB.
- Misaligned: LW/SW with addr[1:0]≠0; LH/LHU/SH with addr[0]≠0. No memory request issued.
- REQ: dmem_req_valid_out=1, fields stable until dmem_req_ready_in. On accept: LOAD -> RESP, STORE -> WB.
- Store strobes: SB 4'b0001<<addr[1:0], wdata={4{data[7:0]}}; SH 4'b0011<<addr[1:0], wdata={2{data[15:0]}}; SW 4'b1111, wdata=data.
- RESP: wait for dmem_resp_valid_in; register aligned result -> WB. Byte lane = resp>>(8*addr[1:0]); LB/LH sign-extend from bit 7/15, LBU/LHU zero-extend, LW whole word.
- WB: wb_valid_out=1, record stable until wb_ready_in, then -> IDLE.
- wb_data_out: loads = aligned result; JAL/JALR = data (link value supplied by execute); STORE/misaligned = 0; others = data.
- wb_we_out = 0 for STORE, BRANCH, misaligned, UNSUPPORTED, or dst==0; else 1.
- Reset (any time, any state): state=IDLE, all outputs 0 except e_ready_out=1 one cycle after reset releases (0 while asserted). An in-flight memory request is abandoned; data memory is reset by the same rst_in.

## Timing
- Non-memory: accepted cycle N -> wb_valid_out N+1.
- Load: accept N, dmem_req_valid_out N+1; req accepted at N+k, response at cycle M>N+k -> wb_valid_out M+1.
- Store: accept N, request N+1, ready at N+k -> wb_valid_out N+k+1.
- Response coinciding with the request-accept cycle is illegal; ignored outside RESP.
- Back-to-back throughput: one instruction per 2 cycles minimum (accept, WB) with wb_ready_in held high.
- misaligned_out asserted exactly the cycle the stage enters WB.

## Structure
- Add to ProcTypes: `MemStageState` enum (IDLE, REQ, RESP, WB); `WbInst` struct {dst, data, we}.
- One combinational sub-module `mem_align`: store strobe/replication, load extraction/extension, misalignment detect, keyed on memFunc and addr[1:0].

## Test plan
- ADD result data=32'h1234, dst=5, wb_ready high -> wb_valid one cycle after accept, wb_data=32'h1234, we=1.
- LB addr=32'h103, resp data=32'h80FF_0000 -> req addr 32'h100, wstrb 0, wb_data=32'hFFFF_FF80.
- SH addr=32'h202, data=32'hABCD_5678, req_ready delayed 3 cycles -> wstrb 4'b1100, wdata 32'h5678_5678 held stable, wb we=0.
- LW addr=32'h101 -> no dmem_req_valid, misaligned_out one pulse, wb we=0.
- LHU addr=32'h2, resp 32'hBEEF_0000, wb_ready low 4 cycles -> wb_data=32'h0000_BEEF held stable; e_ready low until consumed.
- rst_in asserted during RESP -> outputs clear asynchronously, late dmem_resp_valid ignored, next ADD completes normally.
